// File: rtl/sram_1r1w_ecc_ctrl.sv
// ============================================================================
// Module : sram_1r1w_ecc_ctrl
// Brief  : SECDED host controller and background scrubber for a 256x32 1R1W SRAM
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_1r1w_ecc_ctrl #(
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             ce,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_addr,
  input  logic [25:0]      wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [7:0]       rd_addr,
  output logic             rsp_valid,
  output logic [25:0]      rsp_data,
  output logic             rsp_sbe,
  output logic             rsp_dbe,
  input  logic             scrub_en,
  output logic [CNT_W-1:0] sbe_cnt,
  output logic [CNT_W-1:0] dbe_cnt,
  output logic [7:0]       a1,
  output logic             csb1,
  output logic             oeb1,
  input  logic [31:0]      o1,
  output logic [7:0]       a2,
  output logic             csb2,
  output logic             web2,
  output logic [31:0]      i2
);

  localparam int              c_iw        = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [c_iw-1:0] c_icnt_last = c_iw'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_WB   = 3'd3,
    S_NEXT = 3'd4
  } scrub_state_t;

  // Data fills non-power-of-two Hamming positions 3..31 in ascending order.
  function automatic logic [31:0] ecc_encode(input logic [25:0] d);
    logic [31:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      par = 1'b0;
      for (int p = 3; p < 32; p++) begin
        if (((p >> k) & 1) != 0) par = par ^ cw[p];
      end
      cw[1 << k] = par;
    end
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  function automatic logic [25:0] ecc_extract(input logic [31:0] cw);
    logic [25:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  scrub_state_t     r_state, w_state_nxt;
  logic [c_iw-1:0]  r_icnt, w_icnt_nxt;
  logic [7:0]       r_scrub_addr, w_saddr_nxt;
  logic [31:0]      r_scrub_cw, w_cw_nxt;
  logic             r_stale, w_stale_nxt;
  logic             r_ready;
  logic             r_rd_p1;
  logic             r_rsp_valid, r_rsp_sbe, r_rsp_dbe;
  logic [25:0]      r_rsp_data;
  logic [CNT_W-1:0] r_sbe_cnt, r_dbe_cnt;

  logic             w_wr_acc, w_rd_acc, w_wr_hit, w_chk;
  logic [4:0]       w_syn;
  logic             w_po, w_sbe, w_dbe;
  logic [31:0]      w_cor;
  logic [1:0]       w_sbe_inc, w_dbe_inc;

  assign w_wr_acc = wr_valid & r_ready;
  assign w_rd_acc = rd_valid & r_ready;
  assign w_wr_hit = w_wr_acc && (wr_addr == r_scrub_addr);
  assign w_chk    = (r_state == S_CHK);

  // Single decoder on O1: host and scrub reads never share a cycle on port 1.
  always_comb begin
    w_syn = '0;
    for (int p = 1; p < 32; p++) begin
      if (o1[p]) w_syn = w_syn ^ 5'(p);
    end
    w_po  = ^o1;
    w_cor = o1;
    if (w_po) w_cor[w_syn] = ~o1[w_syn];
  end

  assign w_sbe     = w_po;
  assign w_dbe     = ~w_po & (w_syn != 5'd0);
  assign w_sbe_inc = {1'b0, r_rd_p1 & w_sbe} + {1'b0, w_chk & w_sbe};
  assign w_dbe_inc = {1'b0, r_rd_p1 & w_dbe} + {1'b0, w_chk & w_dbe};

  // SRAM port drive: host first, scrubber only on idle host cycles.
  always_comb begin
    a1   = '0;
    csb1 = 1'b1;
    a2   = '0;
    csb2 = 1'b1;
    web2 = 1'b1;
    i2   = '0;
    if (!rst) begin
      if (w_rd_acc) begin
        a1   = rd_addr;
        csb1 = 1'b0;
      end else if (r_state == S_RD) begin
        a1   = r_scrub_addr;
        csb1 = 1'b0;
      end
      if (w_wr_acc) begin
        a2   = wr_addr;
        i2   = ecc_encode(wr_data);
        csb2 = 1'b0;
        web2 = 1'b0;
      end else if (r_state == S_WB && !wr_valid) begin
        a2   = r_scrub_addr;
        i2   = r_scrub_cw;
        csb2 = 1'b0;
        web2 = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_icnt_nxt  = r_icnt;
    w_saddr_nxt = r_scrub_addr;
    w_cw_nxt    = r_scrub_cw;
    w_stale_nxt = r_stale;
    case (r_state)
      S_WAIT: begin
        if (scrub_en) begin
          if (r_icnt == c_icnt_last) begin
            w_icnt_nxt  = '0;
            w_state_nxt = S_RD;
          end else begin
            w_icnt_nxt = r_icnt + 1'b1;
          end
        end
      end
      S_RD: begin
        // A host write landing with the scrub read would make the read data stale.
        w_stale_nxt = w_wr_hit;
        if (!rd_valid) w_state_nxt = S_CHK;
      end
      S_CHK: begin
        w_cw_nxt = w_cor;
        if (w_wr_hit || r_stale) w_state_nxt = S_NEXT;
        else if (w_sbe)          w_state_nxt = S_WB;
        else                     w_state_nxt = S_NEXT;
      end
      S_WB: begin
        if (w_wr_hit || !wr_valid) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_saddr_nxt = r_scrub_addr + 8'd1;
        w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge ce) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_sbe    <= 1'b0;
      r_rsp_dbe    <= 1'b0;
      r_sbe_cnt    <= '0;
      r_dbe_cnt    <= '0;
      r_state      <= S_WAIT;
      r_icnt       <= '0;
      r_scrub_addr <= '0;
      r_scrub_cw   <= '0;
      r_stale      <= 1'b0;
    end else begin
      r_ready      <= 1'b1;
      r_rd_p1      <= w_rd_acc;
      r_rsp_valid  <= r_rd_p1;
      r_rsp_sbe    <= r_rd_p1 & w_sbe;
      r_rsp_dbe    <= r_rd_p1 & w_dbe;
      if (r_rd_p1) r_rsp_data <= ecc_extract(w_cor);
      r_sbe_cnt    <= sat_add(r_sbe_cnt, w_sbe_inc);
      r_dbe_cnt    <= sat_add(r_dbe_cnt, w_dbe_inc);
      r_state      <= w_state_nxt;
      r_icnt       <= w_icnt_nxt;
      r_scrub_addr <= w_saddr_nxt;
      r_scrub_cw   <= w_cw_nxt;
      r_stale      <= w_stale_nxt;
    end
  end

  assign wr_ready  = r_ready;
  assign rd_ready  = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_sbe   = r_rsp_sbe;
  assign rsp_dbe   = r_rsp_dbe;
  assign sbe_cnt   = r_sbe_cnt;
  assign dbe_cnt   = r_dbe_cnt;
  assign oeb1      = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sram_1r1w_ecc_ctrl.sv
// ============================================================================
// Module : tb_sram_1r1w_ecc_ctrl
// Brief  : Scoreboard bench for sram_1r1w_ecc_ctrl with a behavioural 1R1W SRAM
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_1r1w_ecc_ctrl;

  localparam int SCRUB_INTERVAL = 4;
  localparam int CNT_W          = 4;

  logic             ce = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0, rd_valid = 1'b0, scrub_en = 1'b0;
  logic [7:0]       wr_addr = '0, rd_addr = '0;
  logic [25:0]      wr_data = '0;
  logic             wr_ready, rd_ready, rsp_valid, rsp_sbe, rsp_dbe;
  logic [25:0]      rsp_data;
  logic [CNT_W-1:0] sbe_cnt, dbe_cnt;
  logic [7:0]       a1, a2;
  logic             csb1, oeb1, csb2, web2;
  logic [31:0]      o1 = '0, i2;

  logic [31:0] mem [256];
  int          tests = 0, errors = 0, cyc = 0, rsp_count = 0;
  int          scrub_wr_cnt = 0, scrub_rd_cnt = 0;
  logic [7:0]  last_scrub_a = '0, prev_scrub_a = '0;

  typedef struct {
    logic [25:0] data;
    logic        sbe;
    logic        dbe;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  sram_1r1w_ecc_ctrl #(.SCRUB_INTERVAL(SCRUB_INTERVAL), .CNT_W(CNT_W)) dut (
    .ce(ce), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sbe(rsp_sbe), .rsp_dbe(rsp_dbe),
    .scrub_en(scrub_en), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
    .a1(a1), .csb1(csb1), .oeb1(oeb1), .o1(o1),
    .a2(a2), .csb2(csb2), .web2(web2), .i2(i2)
  );

  always #5 ce = ~ce;

  // Behavioural SRAM: read data appears the cycle after the read; read-before-write on collision.
  always @(posedge ce) begin
    cyc = cyc + 1;
    if (csb1 === 1'b0) begin
      o1 <= mem[a1];
      if (!rd_valid) begin
        prev_scrub_a = last_scrub_a;
        last_scrub_a = a1;
        scrub_rd_cnt = scrub_rd_cnt + 1;
      end
    end
    if (csb2 === 1'b0 && web2 === 1'b0) begin
      mem[a2] <= i2;
      if (!wr_valid) scrub_wr_cnt = scrub_wr_cnt + 1;
    end
  end

  always @(negedge ce) begin
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      tests++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got RSP_VALID data=%h sbe=%b dbe=%b, required no response", rsp_data, rsp_sbe, rsp_dbe);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_data !== mon_e.data || rsp_sbe !== mon_e.sbe || rsp_dbe !== mon_e.dbe || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL rsp_check: got data=%h sbe=%b dbe=%b cyc=%0d, required data=%h sbe=%b dbe=%b cyc=%0d",
                   rsp_data, rsp_sbe, rsp_dbe, cyc, mon_e.data, mon_e.sbe, mon_e.dbe, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder built from parity coverage masks.
  function automatic logic [31:0] ref_enc(input logic [25:0] d);
    logic [31:0] cw;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 3; p < 32; p++) begin
      if (p != 4 && p != 8 && p != 16) begin
        cw[p] = d[j];
        j++;
      end
    end
    cw[1]  = ^(cw & 32'hAAAAAAAA);
    cw[2]  = ^(cw & 32'hCCCCCCCC);
    cw[4]  = ^(cw & 32'hF0F0F0F0);
    cw[8]  = ^(cw & 32'hFF00FF00);
    cw[16] = ^(cw & 32'hFFFF0000);
    cw[0]  = ^cw[31:1];
    return cw;
  endfunction

  task automatic tick();
    @(posedge ce);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic apply_reset();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    scrub_en = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic issue_read(input logic [7:0] addr, input logic [25:0] d, input logic s, input logic b);
    exp_t e;
    e.data = d; e.sbe = s; e.dbe = b; e.cyc = cyc + 2;
    rd_valid = 1'b1;
    rd_addr  = addr;
    sb.push_back(e);
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tests++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    @(negedge ce);
    tests++;
    if ({rsp_valid, rsp_sbe, rsp_dbe, rsp_data} !== 29'h0) begin
      errors++; $display("FAIL reset_rsp: got %h, required 0", {rsp_valid, rsp_sbe, rsp_dbe, rsp_data});
    end
    tests++;
    if ({sbe_cnt, dbe_cnt} !== 8'h0) begin
      errors++; $display("FAIL reset_cnt: got %h, required 0", {sbe_cnt, dbe_cnt});
    end
    tests++;
    if ({csb1, csb2, web2, a1, a2, i2} !== {3'b111, 48'h0}) begin
      errors++; $display("FAIL reset_sram: got %h, required %h", {csb1, csb2, web2, a1, a2, i2}, {3'b111, 48'h0});
    end
    tests++;
    if ({wr_ready, rd_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b, required 00", {wr_ready, rd_ready});
    end
    @(posedge ce); #1;
    rst = 1'b0;
    tick();
    @(negedge ce);
    tests++;
    if ({wr_ready, rd_ready, oeb1} !== 3'b110) begin
      errors++; $display("FAIL ready_after_reset: got %b, required 110", {wr_ready, rd_ready, oeb1});
    end
    @(posedge ce); #1;
  endtask

  task automatic test_basic();
    apply_reset();
    clear_mem();
    wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 26'h0000001;
    @(negedge ce);
    tests++;
    if ({i2, csb2, web2, a2} !== {32'h0000000F, 2'b00, 8'd5}) begin
      errors++; $display("FAIL write_drive: got i2=%h csb2=%b web2=%b a2=%h, required i2=0000000f csb2=0 web2=0 a2=05", i2, csb2, web2, a2);
    end
    @(posedge ce); #1;
    wr_valid = 1'b0;
    issue_read(8'd5, 26'h0000001, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_sbe();
    apply_reset();
    clear_mem();
    mem[7] = 32'h00000007;
    issue_read(8'd7, 26'h0000001, 1'b1, 1'b0);
    drain();
    tests++;
    if ({sbe_cnt, dbe_cnt, mem[7]} !== {4'd1, 4'd0, 32'h00000007}) begin
      errors++; $display("FAIL sbe_host: got sbe_cnt=%0d dbe_cnt=%0d mem7=%h, required 1 0 00000007", sbe_cnt, dbe_cnt, mem[7]);
    end
    mem[7] = 32'h0000000E;
    issue_read(8'd7, 26'h0000001, 1'b1, 1'b0);
    drain();
    tests++;
    if (sbe_cnt !== 4'd2) begin
      errors++; $display("FAIL sbe_bit0: got sbe_cnt=%0d, required 2", sbe_cnt);
    end
  endtask

  task automatic test_dbe();
    apply_reset();
    clear_mem();
    mem[7] = 32'h0000000C;
    issue_read(8'd7, 26'h0000001, 1'b0, 1'b1);
    drain();
    tests++;
    if ({sbe_cnt, dbe_cnt} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL dbe_host: got sbe_cnt=%0d dbe_cnt=%0d, required 0 1", sbe_cnt, dbe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] d [8];
    logic [25:0] nd;
    int          ppos [6];
    int          x, y;
    ppos = '{0, 1, 2, 4, 8, 16};
    apply_reset();
    clear_mem();
    for (int i = 0; i < 8; i++) begin
      d[i]     = 26'($urandom);
      wr_valid = 1'b1; wr_addr = 8'(16 + i); wr_data = d[i];
      @(negedge ce);
      tests++;
      if (i2 !== ref_enc(d[i])) begin
        errors++; $display("FAIL encode_%0d: got %h, required %h", i, i2, ref_enc(d[i]));
      end
      @(posedge ce); #1;
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) issue_read(8'(16 + i), d[i], 1'b0, 1'b0);
    // Read and write of the same address in one cycle: old data comes back.
    nd = ~d[4];
    wr_valid = 1'b1; wr_addr = 8'd20; wr_data = nd;
    issue_read(8'd20, d[4], 1'b0, 1'b0);
    wr_valid = 1'b0;
    issue_read(8'd20, nd, 1'b0, 1'b0);
    drain();
    d[4] = nd;
    for (int i = 0; i < 8; i++) mem[16 + i] = ref_enc(d[i]) ^ (32'h1 << $urandom_range(31, 0));
    for (int i = 0; i < 8; i++) issue_read(8'(16 + i), d[i], 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(5, 0);
      y = (x + $urandom_range(5, 1)) % 6;
      mem[16 + i] = ref_enc(d[i]) ^ (32'h1 << ppos[x]) ^ (32'h1 << ppos[y]);
    end
    for (int i = 0; i < 8; i++) issue_read(8'(16 + i), d[i], 1'b0, 1'b1);
    drain();
    tests++;
    if ({sbe_cnt, dbe_cnt} !== {4'd8, 4'd8}) begin
      errors++; $display("FAIL b2b_counts: got sbe_cnt=%0d dbe_cnt=%0d, required 8 8", sbe_cnt, dbe_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    clear_mem();
    mem[3] = ref_enc(26'h0000155) ^ 32'h00000020;
    mem[4] = ref_enc(26'h2AAAAAA) ^ 32'h00000006;
    for (int i = 0; i < 17; i++) issue_read(8'd3, 26'h0000155, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) issue_read(8'd4, 26'h2AAAAAA, 1'b0, 1'b1);
    drain();
    tests++;
    if ({sbe_cnt, dbe_cnt} !== 8'hFF) begin
      errors++; $display("FAIL saturation: got sbe_cnt=%0d dbe_cnt=%0d, required 15 15", sbe_cnt, dbe_cnt);
    end
  endtask

  task automatic test_scrub();
    int rc0;
    apply_reset();
    clear_mem();
    mem[9]  = 32'h00000007;
    mem[10] = 32'h0000000C;
    scrub_wr_cnt = 0;
    scrub_rd_cnt = 0;
    rc0 = rsp_count;
    scrub_en = 1'b1;
    for (int i = 0; i < 3000 && scrub_rd_cnt < 12; i++) tick();
    tests++;
    if (scrub_rd_cnt < 12) begin
      errors++; $display("FAIL scrub_progress: got %0d scrub reads, required 12", scrub_rd_cnt);
    end
    tests++;
    if ({mem[9], mem[10], sbe_cnt, dbe_cnt} !== {32'h0000000F, 32'h0000000C, 4'd1, 4'd1}) begin
      errors++; $display("FAIL scrub_fix: got mem9=%h mem10=%h sbe=%0d dbe=%0d, required 0000000f 0000000c 1 1", mem[9], mem[10], sbe_cnt, dbe_cnt);
    end
    tests++;
    if (scrub_wr_cnt !== 1) begin
      errors++; $display("FAIL scrub_writes: got %0d, required 1", scrub_wr_cnt);
    end
    for (int i = 0; i < 3000 && scrub_rd_cnt < 257; i++) tick();
    tests++;
    if ({prev_scrub_a, last_scrub_a} !== 16'hFF00 || scrub_rd_cnt < 257) begin
      errors++; $display("FAIL scrub_wrap: got %h->%h after %0d reads, required ff->00", prev_scrub_a, last_scrub_a, scrub_rd_cnt);
    end
    tests++;
    if (rsp_count != rc0) begin
      errors++; $display("FAIL scrub_no_rsp: got %0d responses, required 0", rsp_count - rc0);
    end
    scrub_en = 1'b0;
  endtask

  task automatic test_scrub_cancel();
    int i;
    apply_reset();
    clear_mem();
    mem[9] = 32'h00000007;
    scrub_wr_cnt = 0;
    scrub_en = 1'b1;
    i = 0;
    do begin
      @(negedge ce);
      i++;
    end while (!(csb1 === 1'b0 && a1 === 8'd9 && !rd_valid) && i < 500);
    tests++;
    if (i >= 500) begin
      errors++; $display("FAIL cancel_reach: got no scrub read of addr 9, required one");
    end
    @(posedge ce); #1;
    wr_valid = 1'b1; wr_addr = 8'd9; wr_data = 26'h3FFFFFF;
    tick();
    wr_valid = 1'b0;
    repeat (10) tick();
    scrub_en = 1'b0;
    tests++;
    if ({scrub_wr_cnt, mem[9]} !== {32'd0, ref_enc(26'h3FFFFFF)}) begin
      errors++; $display("FAIL wb_cancel: got scrub writes=%0d mem9=%h, required 0 %h", scrub_wr_cnt, mem[9], ref_enc(26'h3FFFFFF));
    end
    tick();
    issue_read(8'd9, 26'h3FFFFFF, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_stall_and_reset_drop();
    logic [25:0] d [32];
    int          steal, rc0;
    exp_t        e;
    apply_reset();
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      d[i]   = 26'($urandom);
      mem[i] = ref_enc(d[i]);
    end
    scrub_rd_cnt = 0;
    steal    = 0;
    scrub_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rd_valid = 1'b1;
      rd_addr  = 8'($urandom_range(31, 0));
      e.data = d[rd_addr]; e.sbe = 1'b0; e.dbe = 1'b0; e.cyc = cyc + 2;
      sb.push_back(e);
      @(negedge ce);
      if (csb1 !== 1'b0 || a1 !== rd_addr) steal++;
      @(posedge ce); #1;
    end
    rd_valid = 1'b0;
    tests++;
    if (steal != 0 || scrub_rd_cnt != 0) begin
      errors++; $display("FAIL scrub_stall: got %0d port conflicts %0d scrub reads, required 0 0", steal, scrub_rd_cnt);
    end
    @(negedge ce);
    tests++;
    if ({csb1, a1} !== 9'h000) begin
      errors++; $display("FAIL scrub_resume: got csb1=%b a1=%h, required 0 00", csb1, a1);
    end
    @(posedge ce); #1;
    drain();
    scrub_en = 1'b0;
    apply_reset();
    clear_mem();
    mem[7] = 32'h00000007;
    rc0 = rsp_count;
    rd_valid = 1'b1; rd_addr = 8'd7;
    tick();
    rd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    tests++;
    if (rsp_count != rc0 || {sbe_cnt, dbe_cnt} !== 8'h0) begin
      errors++; $display("FAIL reset_drop: got %0d responses sbe=%0d dbe=%0d, required 0 0 0", rsp_count - rc0, sbe_cnt, dbe_cnt);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic();
    test_sbe();
    test_dbe();
    test_back_to_back();
    test_saturation();
    test_scrub();
    test_scrub_cancel();
    test_stall_and_reset_drop();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
